// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and defaults for the Aquila fetch PC unit.
// Holds the fetch sequencer state encoding and the default parameter values.
package fetch_pc_unit_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  // IDLE: first cycle after reset; BUSY: request outstanding; DROP: finishing a
  // killed bus cycle; HOLD: fetched word parked while decode is stalled.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch sequencer for the Aquila RV32IM core.
// Keeps one instruction-memory request outstanding and presents (pc, instr, valid) to decode.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            sys_jump_i,
  input  logic [XLEN-1:0] sys_jump_pc_i,
  input  logic            branch_flush_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [XLEN-1:0] imem_data_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            instr_valid_o
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_pending_pc;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_req;
  logic            r_valid;

  logic            w_redirect;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_next_pc;

  // Next-PC priority: trap/xRET > EXE redirect > predictor > sequential.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    w_redirect    = sys_jump_i | branch_flush_i;
    w_redirect_pc = branch_target_i;
    w_next_pc     = r_fetch_pc + XLEN'(4);
    if (sys_jump_i) begin
      w_redirect_pc = sys_jump_pc_i;
    end
    if (w_redirect) begin
      w_next_pc = w_redirect_pc;
    end else if (pred_taken_i) begin
      w_next_pc = pred_target_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_VEC;
      r_pending_pc <= '0;
      r_req        <= 1'b0;
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_instr      <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register in this block sees pre-edge values, independent of statement order.
      case (r_state)
        S_IDLE: begin
          r_req   <= 1'b1;
          r_state <= S_BUSY;
          if (w_redirect) begin
            r_fetch_pc <= w_redirect_pc;
          end
        end

        S_BUSY: begin
          if (imem_ready_i && !w_redirect) begin
            r_pc       <= r_fetch_pc;
            r_instr    <= imem_data_i;
            r_valid    <= 1'b1;
            r_fetch_pc <= w_next_pc;
            if (stall_i) begin
              r_req   <= 1'b0;
              r_state <= S_HOLD;
            end
          end else if (w_redirect) begin
            r_valid <= 1'b0;
            if (imem_ready_i) begin
              r_fetch_pc <= w_redirect_pc;
            end else begin
              // The bus cycle must still complete at the old address.
              r_pending_pc <= w_redirect_pc;
              r_state      <= S_DROP;
            end
          end else begin
            r_valid <= 1'b0;
          end
        end

        S_DROP: begin
          r_valid <= 1'b0;
          if (w_redirect) begin
            r_pending_pc <= w_redirect_pc;
          end
          if (imem_ready_i) begin
            r_fetch_pc <= w_redirect ? w_redirect_pc : r_pending_pc;
            r_state    <= S_BUSY;
          end
        end

        S_HOLD: begin
          if (w_redirect) begin
            r_valid    <= 1'b0;
            r_fetch_pc <= w_redirect_pc;
            r_req      <= 1'b1;
            r_state    <= S_BUSY;
          end else if (!stall_i) begin
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_BUSY;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = {r_fetch_pc[XLEN-1:2], 2'b00};
  assign pc_o          = r_pc;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by randomized traffic,
// each cycle compared against a transaction-level fetch model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        sys_jump_i;
  logic [31:0] sys_jump_pc_i;
  logic        branch_flush_i;
  logic [31:0] branch_target_i;
  logic        pred_taken_i;
  logic [31:0] pred_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;

  always #5 clk_i = ~clk_i;

  fetch_pc_unit #(.XLEN(32), .RESET_VEC(RESET_VEC)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .sys_jump_i     (sys_jump_i),
    .sys_jump_pc_i  (sys_jump_pc_i),
    .branch_flush_i (branch_flush_i),
    .branch_target_i(branch_target_i),
    .pred_taken_i   (pred_taken_i),
    .pred_target_i  (pred_target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ready_i   (imem_ready_i),
    .imem_data_i    (imem_data_i),
    .pc_o           (pc_o),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: a request is either absent, live, or poisoned by a redirect;
  // a delivered word is either flowing or parked for a stalled decode.
  bit          m_started, m_out, m_poison, m_hold, m_valid;
  logic [31:0] m_pc, m_pend, m_opc, m_oinstr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0020) return 32'h0000_0013;
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1357};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_out     = 1'b0;
    m_poison  = 1'b0;
    m_hold    = 1'b0;
    m_valid   = 1'b0;
    m_pc      = RESET_VEC;
    m_pend    = '0;
    m_opc     = '0;
    m_oinstr  = '0;
  endtask

  task automatic model_edge();
    bit          redir;
    bit          done;
    logic [31:0] tgt;
    redir = sys_jump_i | branch_flush_i;
    tgt   = sys_jump_i ? sys_jump_pc_i : branch_target_i;
    done  = m_out && imem_ready_i;
    if (!m_started) begin
      m_started = 1'b1;
      m_out     = 1'b1;
      if (redir) m_pc = tgt;
    end else if (m_hold) begin
      if (redir || !stall_i) begin
        m_hold  = 1'b0;
        m_out   = 1'b1;
        m_valid = 1'b0;
        if (redir) m_pc = tgt;
      end
    end else if (m_poison) begin
      if (redir) m_pend = tgt;
      if (done) begin
        m_pc     = m_pend;
        m_poison = 1'b0;
      end
    end else if (redir) begin
      m_valid = 1'b0;
      if (done) m_pc = tgt;
      else begin
        m_pend   = tgt;
        m_poison = 1'b1;
      end
    end else if (done) begin
      m_valid  = 1'b1;
      m_opc    = m_pc;
      m_oinstr = imem_data_i;
      m_pc     = pred_taken_i ? pred_target_i : m_pc + 32'd4;
      if (stall_i) begin
        m_hold = 1'b1;
        m_out  = 1'b0;
      end
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive(input bit rdy, input bit st = 1'b0, input bit bf = 1'b0,
                       input logic [31:0] bt = '0, input bit sj = 1'b0,
                       input logic [31:0] sjpc = '0, input bit pt = 1'b0,
                       input logic [31:0] ptgt = '0);
    imem_ready_i    = rdy;
    stall_i         = st;
    branch_flush_i  = bf;
    branch_target_i = bt;
    sys_jump_i      = sj;
    sys_jump_pc_i   = sjpc;
    pred_taken_i    = pt;
    pred_target_i   = ptgt;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".req"},   32'(imem_req_o),    32'(m_out));
    check({tag, ".addr"},  imem_addr_o,        {m_pc[31:2], 2'b00});
    check({tag, ".valid"}, 32'(instr_valid_o), 32'(m_valid));
    check({tag, ".pc"},    pc_o,               m_opc);
    check({tag, ".instr"}, instr_o,            m_oinstr);
  endtask

  // One clock: memory answers with the word at the modelled request address.
  task automatic cycle(input string tag);
    imem_data_i = imem_ready_i ? mem_fn({m_pc[31:2], 2'b00}) : 32'hDEAD_BEEF;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   32'(imem_req_o),    32'd0);
    check({tag, ".valid"}, 32'(instr_valid_o), 32'd0);
    check({tag, ".pc"},    pc_o,               32'd0);
    check({tag, ".instr"}, instr_o,            32'd0);
    check({tag, ".addr"},  imem_addr_o,        RESET_VEC);
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0);
    imem_data_i = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // 1: back-to-back fetches from the reset vector
    drive(1'b1);
    cycle("t1.c0");
    check("t1.addr0", imem_addr_o, 32'h0);
    cycle("t1.c1");
    check("t1.addr4", imem_addr_o, 32'h4);
    check("t1.pc0", pc_o, 32'h0);
    cycle("t1.c2");
    check("t1.addr8", imem_addr_o, 32'h8);
    check("t1.pc4", pc_o, 32'h4);
    check("t1.valid", 32'(instr_valid_o), 32'd1);

    // 2: redirect while a request to 0x10 is stalled on memory
    drive(1'b1, 1'b0, 1'b1, 32'h10);
    cycle("t2.go");
    check("t2.addr10", imem_addr_o, 32'h10);
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    cycle("t2.flush");
    check("t2.drop_addr", imem_addr_o, 32'h10);
    check("t2.drop_req", 32'(imem_req_o), 32'd1);
    drive(1'b0);
    cycle("t2.w1");
    cycle("t2.w2");
    drive(1'b1);
    cycle("t2.done");
    check("t2.addr100", imem_addr_o, 32'h100);
    check("t2.novalid", 32'(instr_valid_o), 32'd0);
    cycle("t2.cap");
    check("t2.pc100", pc_o, 32'h100);

    // 3: trap beats branch flush
    drive(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h8000_0000);
    cycle("t3.prio");
    check("t3.addr", imem_addr_o, 32'h8000_0000);

    // 4: word captured under stall is held, no request, resumes at 0x24
    drive(1'b1, 1'b0, 1'b1, 32'h20);
    cycle("t4.go");
    drive(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle("t4.hold");
      check("t4.pc", pc_o, 32'h20);
      check("t4.instr", instr_o, 32'h0000_0013);
      check("t4.noreq", 32'(imem_req_o), 32'd0);
    end
    drive(1'b1);
    cycle("t4.release");
    check("t4.addr24", imem_addr_o, 32'h24);
    check("t4.req", 32'(imem_req_o), 32'd1);

    // 5: predicted-taken target, then sequential wrap past the top of memory
    drive(1'b1, 1'b0, 1'b1, 32'h30);
    cycle("t5.go");
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h40);
    cycle("t5.pred");
    check("t5.addr40", imem_addr_o, 32'h40);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
    cycle("t5.top");
    drive(1'b1);
    cycle("t5.wrap");
    check("t5.addr0", imem_addr_o, 32'h0);
    check("t5.pctop", pc_o, 32'hFFFF_FFFC);

    // Unaligned target: address low bits are forced to zero
    drive(1'b1, 1'b0, 1'b1, 32'h103);
    cycle("ua.go");
    check("ua.addr", imem_addr_o, 32'h100);
    drive(1'b1);
    cycle("ua.next");

    // 6: asynchronous reset while a killed request is draining
    drive(1'b1, 1'b0, 1'b1, 32'h10);
    cycle("t6.go");
    drive(1'b0, 1'b0, 1'b1, 32'h300);
    cycle("t6.drop");
    drive(1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("t6.rst");
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(1'b1);
    cycle("t6.first");
    check("t6.addr", imem_addr_o, RESET_VEC);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r_bt, r_sj, r_pt;
      r_bt = $urandom & 32'hFFFF_FFFC;
      r_sj = $urandom & 32'hFFFF_FFFC;
      r_pt = $urandom & 32'hFFFF_FFFC;
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
            $urandom_range(0, 11) == 0, r_bt, $urandom_range(0, 24) == 0, r_sj,
            $urandom_range(0, 9) < 2, r_pt);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
